dmem_io_ctrl: RTL and testbench

Data-memory and memory-mapped I/O controller for the multicycle bus processor. It accepts one load/store request at a time from the processor microcode (MAR/MDR side) and decodes the address to on-chip data memory or to the board I/O registers (HEX, LEDR, LEDG, KEY, SW). It sequences the synchronous-read memory and returns read data with a one-cycle `done` pulse. It also flags misaligned or unmapped accesses so the control FSM can enter its error state.

---
 rtl/dmem_io_if.sv | 23 ++
 rtl/dmem_io_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_io_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_if.sv
// Processor-side load/store bus between the microcode datapath and dmem_io_ctrl.
interface dmem_io_if #(
  parameter int DBITS = 32
) ();
  logic             req;
  logic             we;
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, done, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, done, err, busy
  );
endinterface

// File: rtl/dmem_io_ctrl.sv
// Data memory plus memory-mapped board I/O (HEX/LEDR/LEDG/KEY/SW) behind a
// one-request-at-a-time load/store handshake.
//
// state | meaning
// IDLE  | waiting for req; decode and store commit happen on the accepting edge
// MRD   | synchronous memory read in flight, result captured into rdata
// ACK   | done pulse (err if the access faulted)
module dmem_io_ctrl #(
  parameter int               DBITS        = 32,
  parameter int               DMEMADDRBITS = 13,
  parameter int               DMEMWORDS    = 2048,
  parameter logic [DBITS-1:0] ADDRHEX      = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDRLEDR     = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDRLEDG     = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDRKEY      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDRSW       = 32'hF0000014
) (
  input  logic        clk,
  input  logic        reset,
  dmem_io_if.slave    bus,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  output logic [15:0] hex,
  output logic [9:0]  ledr,
  output logic [7:0]  ledg
);

  typedef enum logic [1:0] {S_IDLE, S_MRD, S_ACK} state_t;

  localparam logic [DBITS-1:0] MEM_LIMIT = DBITS'(DMEMWORDS * 4);

  state_t state, state_nx;

  logic [DBITS-1:0]        mem [DMEMWORDS];
  logic [DBITS-1:0]        mem_q;
  logic [DMEMADDRBITS-3:0] widx;

  logic [3:0]       key_s1, key_s2;
  logic [9:0]       sw_s1, sw_s2;
  logic [15:0]      hex_q;
  logic [9:0]       ledr_q;
  logic [7:0]       ledg_q;
  logic [DBITS-1:0] rdata_q;
  logic             done_q, err_q, busy_q;

  logic aligned, sel_mem, sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;
  logic sel_io, fault, accept;
  logic [DBITS-1:0] io_rd;

  assign widx     = bus.addr[DMEMADDRBITS-1:2];
  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign sel_mem  = aligned && (bus.addr < MEM_LIMIT);
  assign sel_hex  = (bus.addr == ADDRHEX);
  assign sel_ledr = (bus.addr == ADDRLEDR);
  assign sel_ledg = (bus.addr == ADDRLEDG);
  assign sel_key  = (bus.addr == ADDRKEY);
  assign sel_sw   = (bus.addr == ADDRSW);
  assign sel_io   = sel_hex || sel_ledr || sel_ledg || sel_key || sel_sw;
  assign fault    = !(sel_mem || sel_io);
  assign accept   = (state == S_IDLE) && bus.req;

  always_comb begin
    io_rd = '0;
    if (sel_hex)       io_rd[15:0] = hex_q;
    else if (sel_ledr) io_rd[9:0]  = ledr_q;
    else if (sel_ledg) io_rd[7:0]  = ledg_q;
    else if (sel_key)  io_rd[3:0]  = ~key_s2;
    else if (sel_sw)   io_rd[9:0]  = sw_s2;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.req) state_nx = (sel_mem && !bus.we) ? S_MRD : S_ACK;
      S_MRD:  state_nx = S_ACK;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory is not reset; the read port only samples on acceptance so rdata
  // cannot follow a changing address while the load is in flight.
  always_ff @(posedge clk) begin
    if (accept && bus.we && sel_mem) mem[widx] <= bus.wdata;
    if (accept) mem_q <= mem[widx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= 4'b1111;
      key_s2 <= 4'b1111;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      hex_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != S_IDLE);
      done_q <= (state_nx == S_ACK);
      err_q  <= accept && fault;
      if (accept && bus.we) begin
        if (sel_hex)  hex_q  <= bus.wdata[15:0];
        if (sel_ledr) ledr_q <= bus.wdata[9:0];
        if (sel_ledg) ledg_q <= bus.wdata[7:0];
      end
      if (accept && !bus.we) begin
        if (fault)       rdata_q <= '0;
        else if (sel_io) rdata_q <= io_rd;
      end else if (state == S_MRD) begin
        rdata_q <= mem_q;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign hex       = hex_q;
  assign ledr      = ledr_q;
  assign ledg      = ledg_q;

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Directed bench for dmem_io_ctrl: transaction-level reference model checked
// every cycle, plus literal expectations on the directed transactions.
module tb_dmem_io_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] hex;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  dmem_io_if bus ();

  dmem_io_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .key_n (key_n),
    .sw    (sw),
    .hex   (hex),
    .ledr  (ledr),
    .ledg  (ledg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [int unsigned];
  logic        m_act, m_fault, m_upd;
  int          m_age, m_lat;
  logic [31:0] m_pending;
  logic [31:0] e_rdata;
  logic [15:0] e_hex;
  logic [9:0]  e_ledr;
  logic [7:0]  e_ledg;
  logic [3:0]  k_d1, k_d2;
  logic [9:0]  s_d1, s_d2;

  // 0 fault, 1 memory, 2 HEX, 3 LEDR, 4 LEDG, 5 KEY, 6 SW
  function automatic int kind_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a < 32'd8192) return 1;
    case (a)
      32'hF0000000: return 2;
      32'hF0000004: return 3;
      32'hF0000008: return 4;
      32'hF0000010: return 5;
      32'hF0000014: return 6;
      default:      return 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_age = 0; m_lat = 1; m_upd = 1'b0; m_fault = 1'b0;
      e_rdata = '0; e_hex = '0; e_ledr = '0; e_ledg = '0;
      k_d1 = 4'hF; k_d2 = 4'hF; s_d1 = '0; s_d2 = '0;
    end else begin
      if (m_act) begin
        m_age++;
        if (m_age == m_lat) m_act = 1'b0;
        else if (m_upd) e_rdata = m_pending;
      end else if (bus.req) begin
        int k;
        k = kind_of(bus.addr);
        m_act = 1'b1; m_age = 0; m_lat = 1; m_upd = 1'b0; m_fault = (k == 0);
        if (bus.we) begin
          case (k)
            1: mm[bus.addr >> 2] = bus.wdata;
            2: e_hex  = bus.wdata[15:0];
            3: e_ledr = bus.wdata[9:0];
            4: e_ledg = bus.wdata[7:0];
            default: ;
          endcase
        end else begin
          case (k)
            0: e_rdata = '0;
            1: begin
              m_lat = 2; m_upd = 1'b1;
              m_pending = mm.exists(bus.addr >> 2) ? mm[bus.addr >> 2] : 32'h0;
            end
            2: e_rdata = {16'h0, e_hex};
            3: e_rdata = {22'h0, e_ledr};
            4: e_rdata = {24'h0, e_ledg};
            5: e_rdata = {28'h0, ~k_d2};
            6: e_rdata = {22'h0, s_d2};
            default: ;
          endcase
        end
      end
      k_d2 = k_d1; k_d1 = key_n;
      s_d2 = s_d1; s_d1 = sw;
    end
  end

  always @(negedge clk) begin
    logic e_done;
    e_done = m_act && (m_age == m_lat - 1);
    chk("busy",  {31'h0, bus.busy}, {31'h0, m_act});
    chk("done",  {31'h0, bus.done}, {31'h0, e_done});
    chk("err",   {31'h0, bus.err},  {31'h0, e_done && m_fault});
    chk("rdata", bus.rdata, e_rdata);
    chk("hex",   {16'h0, hex},  {16'h0, e_hex});
    chk("ledr",  {22'h0, ledr}, {22'h0, e_ledr});
    chk("ledg",  {24'h0, ledg}, {24'h0, e_ledg});
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (bus.busy && n < 10) begin @(negedge clk); n++; end
    if (bus.busy) begin
      checks++;
      $display("FAIL idle_wait: busy still %b after %0d cycles, required 0", bus.busy, n);
    end
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0;
    lat = 1;
    while (!bus.done && lat < 6) begin @(negedge clk); lat++; end
    if (!bus.done) begin
      checks++;
      $display("FAIL done_wait: done %b after %0d cycles, required 1", bus.done, lat);
    end
    rd = bus.rdata;
    er = bus.err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          dn;

  initial begin
    reset = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    key_n = 4'hF; sw = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_hex", {16'h0, hex}, 32'h0);

    xfer(1'b1, 32'h100, 32'h12345678, rd, er, lat);
    chk("st_mem_lat", lat, 1);
    chk("st_mem_err", {31'h0, er}, 32'h0);
    xfer(1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("ld_mem_lat", lat, 2);
    chk("ld_mem_rdata", rd, 32'h12345678);
    chk("ld_mem_err", {31'h0, er}, 32'h0);

    xfer(1'b1, 32'h1FFC, 32'hCAFEF00D, rd, er, lat);
    xfer(1'b0, 32'h1FFC, 32'h0, rd, er, lat);
    chk("ld_top_word", rd, 32'hCAFEF00D);

    xfer(1'b1, 32'hF0000000, 32'hFFFFABCD, rd, er, lat);
    xfer(1'b1, 32'hF0000004, 32'h000003FF, rd, er, lat);
    xfer(1'b1, 32'hF0000008, 32'h000001A5, rd, er, lat);
    chk("hex_val", {16'h0, hex}, 32'hABCD);
    chk("ledr_val", {22'h0, ledr}, 32'h3FF);
    chk("ledg_val", {24'h0, ledg}, 32'hA5);
    xfer(1'b0, 32'hF0000000, 32'h0, rd, er, lat);
    chk("rd_hex", rd, 32'h0000ABCD);
    chk("rd_hex_lat", lat, 1);
    xfer(1'b0, 32'hF0000004, 32'h0, rd, er, lat);
    chk("rd_ledr", rd, 32'h000003FF);
    xfer(1'b0, 32'hF0000008, 32'h0, rd, er, lat);
    chk("rd_ledg", rd, 32'h000000A5);

    key_n = 4'b1010; sw = 10'h2C3;
    repeat (3) @(negedge clk);
    xfer(1'b0, 32'hF0000010, 32'h0, rd, er, lat);
    chk("rd_key", rd, 32'h5);
    xfer(1'b0, 32'hF0000014, 32'h0, rd, er, lat);
    chk("rd_sw", rd, 32'h2C3);
    xfer(1'b1, 32'hF0000014, 32'hFFFFFFFF, rd, er, lat);
    chk("st_sw_err", {31'h0, er}, 32'h0);
    chk("st_sw_rdata_kept", rd, 32'h2C3);

    xfer(1'b0, 32'h102, 32'h0, rd, er, lat);
    chk("misalign_lat", lat, 1);
    chk("misalign_err", {31'h0, er}, 32'h1);
    chk("misalign_rdata", rd, 32'h0);
    xfer(1'b0, 32'hF0000010, 32'h0, rd, er, lat);
    xfer(1'b0, 32'h2000, 32'h0, rd, er, lat);
    chk("unmapped_lat", lat, 1);
    chk("unmapped_err", {31'h0, er}, 32'h1);
    chk("unmapped_rdata", rd, 32'h0);
    xfer(1'b1, 32'hF000000C, 32'h12345678, rd, er, lat);
    chk("st_hole_err", {31'h0, er}, 32'h1);
    chk("st_hole_hex", {16'h0, hex}, 32'hABCD);
    chk("st_hole_ledr", {22'h0, ledr}, 32'h3FF);
    chk("st_hole_ledg", {24'h0, ledg}, 32'hA5);

    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h100;
    dn = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    bus.req = 1'b0;
    chk("held_req_dones", dn, 3);
    chk("held_req_rdata", bus.rdata, 32'h12345678);

    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h1FFC;
    @(negedge clk);
    bus.req = 1'b0;
    chk("mrd_busy", {31'h0, bus.busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_mid_done", {31'h0, bus.done}, 32'h0);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    chk("rst_mid_hex", {16'h0, hex}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    xfer(1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("post_rst_ld", rd, 32'h12345678);
    chk("post_rst_lat", lat, 2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end
endmodule
